anti_theft_timer: RTL and testbench
===================================

ANTI_THEFT_TIMER -- requirements
Module: anti_theft_timer

Interface
REQ-001 Parameter T_ARM_DELAY, default 6, arming-delay seconds (interval 00).
REQ-002 Parameter T_DRIVER_DELAY, default 8, driver-door countdown seconds (interval 01).
REQ-003 Parameter T_PASSENGER_DELAY, default 15, passenger-door countdown seconds (interval 10).
REQ-004 Parameter T_ALARM_ON, default 10, siren-on seconds (interval 11).
REQ-005 Port clock, input, 1, the single system clock; all logic on rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port start_timer, input, 1, level request from the alarm FSM; high = timer run requested.
REQ-008 Port interval, input, 2, selects which parameter register loads the countdown.
REQ-009 Port one_hz_enable, input, 1, one-cycle tick, once per second.
REQ-010 Port reprogram, input, 1, write strobe for the parameter bank.
REQ-011 Port param_sel, input, 2, parameter register written on reprogram (same encoding as interval).
REQ-012 Port param_value, input, 4, value written on reprogram.
REQ-013 Port expired, output, 1, one-cycle pulse when the countdown reaches zero.
REQ-014 Port count, output, 4, remaining seconds of the current run; 0 when not running.
REQ-015 Port busy, output, 1, high while in LOAD or COUNT.

Function
REQ-016 States: IDLE, LOAD, COUNT, EXPIRE, DONE; 3-bit encoding.
REQ-017 IDLE: start_timer high -> LOAD; else stay; count=0.
REQ-018 LOAD (one cycle): count <= selected param register, interval latched into lat_interval; next COUNT; one_hz_enable in this cycle is ignored.
REQ-019 COUNT: each one_hz_enable decrements count by 1; when count==0 (tick-driven or loaded 0) next state EXPIRE.
REQ-020 A loaded value of 0 reaches EXPIRE the cycle after LOAD with no tick required.
REQ-021 EXPIRE (one cycle): expired=1; next DONE; expired is 0 in every other state.
REQ-022 DONE: hold count=0; stay until start_timer low (-> IDLE) or interval != lat_interval (-> LOAD).
REQ-023 In LOAD, COUNT or DONE, start_timer low -> IDLE next cycle, count cleared, no expired pulse.
REQ-024 In COUNT, start_timer high with interval != lat_interval -> LOAD (restart with new interval); takes priority over decrement.
REQ-025 start_timer low has priority over interval change and over expiry in the same cycle.
REQ-026 Decrement never wraps: count stays at 0, never 4'hF.
REQ-027 reprogram high: param register[param_sel] <= param_value at that edge, independent of FSM state.
REQ-028 reprogram and LOAD same cycle on the same register: LOAD uses the pre-write value.
REQ-029 A running countdown is not altered by reprogram; new value applies at next LOAD.
REQ-030 Parameter defaults above 15 are a configuration error; defaults are truncated to 4 bits.

Reset
REQ-031 reset at a clock edge: state=IDLE, count=0, expired=0, busy=0, lat_interval=00.
REQ-032 reset restores all four parameter registers to their parameter defaults.
REQ-033 reset has priority over reprogram, start_timer and one_hz_enable; mid-run reset produces no expired pulse.

Structure
REQ-034 Shared package anti_theft_pkg holds interval encodings (ARM 00, DRIVER 01, PASSENGER 10, ALARM 11), state encodings and default times.
REQ-035 Sub-module param_bank: 4x4-bit register file with sync reset to defaults, one write port, one combinational read port addressed by interval.

Verification
REQ-036 Defaults; start_timer=1, interval=01, tick every 10 cycles -> count 8,7..0, expired one pulse after 8th tick, then DONE, count=0.
REQ-037 reprogram param_sel=10 value=3, then start interval=10 -> expired after exactly 3 ticks; register reads 3 until reset, then 15.
REQ-038 interval=01 running at count=5, interval changes to 11 with start_timer high -> LOAD, count=10, no expired pulse.
REQ-039 start_timer dropped at count=2 -> IDLE next cycle, count=0, expired never asserts; reassert -> fresh load.
REQ-040 reprogram param_sel=00 value=0, start interval=00 -> expired pulse 2 cycles after LOAD entry with no tick.
REQ-041 reset asserted during COUNT with tick same cycle -> IDLE, count=0, expired=0, all params back to 6/8/15/10.

Source files
------------

// File: rtl/anti_theft_timer_pkg.sv
// Shared encodings and default times for the anti-theft countdown timer.
package anti_theft_pkg;

  typedef enum logic [1:0] {
    IV_ARM       = 2'b00,
    IV_DRIVER    = 2'b01,
    IV_PASSENGER = 2'b10,
    IV_ALARM     = 2'b11
  } interval_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COUNT  = 3'd2,
    S_EXPIRE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int DEF_ARM_DELAY       = 6;
  localparam int DEF_DRIVER_DELAY    = 8;
  localparam int DEF_PASSENGER_DELAY = 15;
  localparam int DEF_ALARM_ON        = 10;

endpackage

// File: rtl/anti_theft_timer_param_bank.sv
// Four 4-bit reprogrammable interval registers; one write port, one async read port.
module param_bank
  import anti_theft_pkg::*;
#(
  parameter logic [3:0] DEF_ARM       = 4'(DEF_ARM_DELAY),
  parameter logic [3:0] DEF_DRIVER    = 4'(DEF_DRIVER_DELAY),
  parameter logic [3:0] DEF_PASSENGER = 4'(DEF_PASSENGER_DELAY),
  parameter logic [3:0] DEF_ALARM     = 4'(DEF_ALARM_ON)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic [1:0] raddr,
  output logic [3:0] rdata
);

  logic [3:0][3:0] regs;

  always_ff @(posedge clock) begin
    if (reset) regs <= {DEF_ALARM, DEF_PASSENGER, DEF_DRIVER, DEF_ARM};
    else if (we) regs[waddr] <= wdata;
  end

  // Read sees the pre-write value in a write cycle, so a same-cycle LOAD gets the old time.
  assign rdata = regs[raddr];

endmodule

// File: rtl/anti_theft_timer.sv
// Seconds countdown for the alarm FSM: loads a per-interval time, counts 1 Hz ticks, pulses expired.
module anti_theft_timer
  import anti_theft_pkg::*;
#(
  parameter int T_ARM_DELAY       = DEF_ARM_DELAY,
  parameter int T_DRIVER_DELAY    = DEF_DRIVER_DELAY,
  parameter int T_PASSENGER_DELAY = DEF_PASSENGER_DELAY,
  parameter int T_ALARM_ON        = DEF_ALARM_ON
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       one_hz_enable,
  input  logic       reprogram,
  input  logic [1:0] param_sel,
  input  logic [3:0] param_value,
  output logic       expired,
  output logic [3:0] count,
  output logic       busy
);

  state_t     state;
  logic [1:0] lat_interval;
  logic [3:0] sel_value;

  param_bank #(
    .DEF_ARM      (4'(T_ARM_DELAY)),
    .DEF_DRIVER   (4'(T_DRIVER_DELAY)),
    .DEF_PASSENGER(4'(T_PASSENGER_DELAY)),
    .DEF_ALARM    (4'(T_ALARM_ON))
  ) u_bank (
    .clock(clock),
    .reset(reset),
    .we   (reprogram),
    .waddr(param_sel),
    .wdata(param_value),
    .raddr(interval),
    .rdata(sel_value)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      count        <= 4'd0;
      expired      <= 1'b0;
      busy         <= 1'b0;
      lat_interval <= IV_ARM;
    end else begin
      expired <= 1'b0;
      unique case (state)
        S_IDLE: begin
          count <= 4'd0;
          if (start_timer) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!start_timer) begin
            state <= S_IDLE;
            count <= 4'd0;
            busy  <= 1'b0;
          end else begin
            state        <= S_COUNT;
            count        <= sel_value;
            lat_interval <= interval;
          end
        end
        // Priority: drop request, then interval change, then expiry, then tick.
        S_COUNT: begin
          if (!start_timer) begin
            state <= S_IDLE;
            count <= 4'd0;
            busy  <= 1'b0;
          end else if (interval != lat_interval) begin
            state <= S_LOAD;
          end else if (count == 4'd0) begin
            state   <= S_EXPIRE;
            expired <= 1'b1;
            busy    <= 1'b0;
          end else if (one_hz_enable) begin
            count <= count - 4'd1;
          end
        end
        S_EXPIRE: begin
          state <= S_DONE;
          count <= 4'd0;
        end
        S_DONE: begin
          count <= 4'd0;
          if (!start_timer) begin
            state <= S_IDLE;
          end else if (interval != lat_interval) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= 4'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anti_theft_timer.sv
// Vector table plus hand sequences; expected outputs queued at drive time, checked after the edge.
module tb_anti_theft_timer;

  logic       clock = 1'b0;
  logic       reset, start_timer, one_hz_enable, reprogram;
  logic [1:0] interval, param_sel;
  logic [3:0] param_value;
  logic       expired, busy;
  logic [3:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  anti_theft_timer dut (
    .clock        (clock),
    .reset        (reset),
    .start_timer  (start_timer),
    .interval     (interval),
    .one_hz_enable(one_hz_enable),
    .reprogram    (reprogram),
    .param_sel    (param_sel),
    .param_value  (param_value),
    .expired      (expired),
    .count        (count),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       st;
    logic [1:0] iv;
    logic       tk;
    logic       rp;
    logic [1:0] ps;
    logic [3:0] pv;
    logic [3:0] ec;
    logic       ee;
    logic       eb;
  } vec_t;

  typedef struct packed {
    logic [3:0] c;
    logic       e;
    logic       b;
    logic       cc;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[16];

  // One clock: drive at negedge, queue expectation, compare #1 after the rising edge.
  task automatic step(input logic rst, st, input logic [1:0] iv, input logic tk, rp,
                      input logic [1:0] ps, input logic [3:0] pv,
                      input logic [3:0] ec, input logic ee, eb, cc, input string nm);
    exp_t x;
    @(negedge clock);
    reset = rst; start_timer = st; interval = iv; one_hz_enable = tk;
    reprogram = rp; param_sel = ps; param_value = pv;
    sbq.push_back('{ec, ee, eb, cc});
    @(posedge clock);
    #1;
    x = sbq.pop_front();
    n_tests++;
    if ((x.cc && count !== x.c) || expired !== x.e || busy !== x.b) begin
      n_fail++;
      $display("FAIL %s: got count=%0d expired=%b busy=%b, want count=%0d expired=%b busy=%b (count checked=%b)",
               nm, count, expired, busy, x.c, x.e, x.b, x.cc);
    end
  endtask

  task automatic run(input logic st, input logic [1:0] iv, input logic tk,
                     input logic [3:0] ec, input logic ee, eb, input string nm);
    step(1'b0, st, iv, tk, 1'b0, 2'd0, 4'd0, ec, ee, eb, 1'b1, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start_timer = 1'b0; interval = 2'd0; one_hz_enable = 1'b0;
    reprogram = 1'b0; param_sel = 2'd0; param_value = 4'd0;

    //          rst st  iv    tk rp ps    pv     ec     ee eb
    tbl[0]  = '{1'b1,1'b0,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,2'd0,1'b0,1'b1,2'd3,4'd1, 4'd0, 1'b0,1'b0}; // reprogram under reset ignored
    tbl[2]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b1}; // -> LOAD
    tbl[4]  = '{1'b0,1'b1,2'd0,1'b1,1'b1,2'd0,4'd0, 4'd6, 1'b0,1'b1}; // pre-write value, tick ignored
    tbl[5]  = '{1'b0,1'b1,2'd0,1'b1,1'b0,2'd0,4'd0, 4'd5, 1'b0,1'b1};
    tbl[6]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b0}; // drop -> IDLE
    tbl[7]  = '{1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b1}; // LOAD arm=0
    tbl[8]  = '{1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b1}; // COUNT at 0
    tbl[9]  = '{1'b0,1'b1,2'd0,1'b1,1'b0,2'd0,4'd0, 4'd0, 1'b1,1'b0}; // EXPIRE, no wrap on tick
    tbl[10] = '{1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b0}; // DONE
    tbl[11] = '{1'b0,1'b1,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b0};
    tbl[13] = '{1'b0,1'b1,2'd3,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b1};
    tbl[14] = '{1'b0,1'b1,2'd3,1'b0,1'b0,2'd0,4'd0, 4'd10,1'b0,1'b1}; // alarm still default
    tbl[15] = '{1'b0,1'b0,2'd3,1'b0,1'b0,2'd0,4'd0, 4'd0, 1'b0,1'b0};

    for (int i = 0; i < 16; i++)
      step(tbl[i].rst, tbl[i].st, tbl[i].iv, tbl[i].tk, tbl[i].rp, tbl[i].ps, tbl[i].pv,
           tbl[i].ec, tbl[i].ee, tbl[i].eb, 1'b1, $sformatf("vec%0d", i));

    // Driver countdown, tick every 10 cycles
    run(1, 2'd1, 0, 4'd0, 0, 1, "drv_load");
    run(1, 2'd1, 1, 4'd8, 0, 1, "drv_cnt8_tick_in_load");
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 9; j++) run(1, 2'd1, 0, 4'(8 - k), 0, 1, "drv_hold");
      run(1, 2'd1, 1, 4'(7 - k), 0, 1, "drv_tick");
    end
    run(1, 2'd1, 0, 4'd0, 1, 0, "drv_expire");
    for (int j = 0; j < 3; j++) run(1, 2'd1, 0, 4'd0, 0, 0, "drv_done");
    run(1, 2'd3, 0, 4'd0, 0, 1, "done_reload");
    run(1, 2'd3, 0, 4'd10, 0, 1, "done_alarm10");
    run(0, 2'd3, 0, 4'd0, 0, 0, "done_drop");

    // Interval switch mid-run, then drop and restart
    run(1, 2'd1, 0, 4'd0, 0, 1, "sw_load");
    run(1, 2'd1, 0, 4'd8, 0, 1, "sw_cnt8");
    for (int i = 0; i < 3; i++) run(1, 2'd1, 1, 4'(7 - i), 0, 1, "sw_tick");
    step(0, 1, 2'd3, 1, 0, 2'd0, 4'd0, 4'd0, 0, 1, 0, "sw_switch");
    run(1, 2'd3, 0, 4'd10, 0, 1, "sw_cnt10");
    for (int i = 0; i < 8; i++) run(1, 2'd3, 1, 4'(9 - i), 0, 1, "drop_tick");
    run(0, 2'd3, 1, 4'd0, 0, 0, "drop_at2");
    run(0, 2'd3, 0, 4'd0, 0, 0, "drop_idle");
    run(0, 2'd3, 0, 4'd0, 0, 0, "drop_idle");
    run(1, 2'd3, 0, 4'd0, 0, 1, "re_load");
    run(1, 2'd3, 0, 4'd10, 0, 1, "re_fresh10");
    for (int i = 0; i < 10; i++) run(1, 2'd3, 1, 4'(9 - i), 0, 1, "re_tick");
    run(0, 2'd3, 0, 4'd0, 0, 0, "drop_beats_expiry");
    run(0, 2'd3, 0, 4'd0, 0, 0, "drop_no_pulse");

    // Reprogrammed passenger time; reprogram of another register mid-run
    step(0, 0, 2'd0, 0, 1, 2'd2, 4'd3, 4'd0, 0, 0, 1, "p_prog3");
    run(1, 2'd2, 0, 4'd0, 0, 1, "p_load");
    run(1, 2'd2, 0, 4'd3, 0, 1, "p_cnt3");
    step(0, 1, 2'd2, 0, 1, 2'd1, 4'd4, 4'd3, 0, 1, 1, "p_prog_midrun");
    for (int i = 0; i < 3; i++) run(1, 2'd2, 1, 4'(2 - i), 0, 1, "p_tick");
    run(1, 2'd2, 0, 4'd0, 1, 0, "p_expire_after3");
    run(1, 2'd2, 0, 4'd0, 0, 0, "p_done");
    run(0, 2'd2, 0, 4'd0, 0, 0, "p_idle");
    run(1, 2'd1, 0, 4'd0, 0, 1, "d4_load");
    run(1, 2'd1, 0, 4'd4, 0, 1, "d4_new_value");
    run(0, 2'd1, 0, 4'd0, 0, 0, "d4_idle");
    run(1, 2'd2, 0, 4'd0, 0, 1, "p_again_load");
    run(1, 2'd2, 0, 4'd3, 0, 1, "p_still3");
    run(1, 2'd2, 1, 4'd2, 0, 1, "p_tick2");

    // Reset mid-count with a tick in the same cycle restores defaults
    step(1, 1, 2'd2, 1, 0, 2'd0, 4'd0, 4'd0, 0, 0, 1, "rst_midrun");
    run(1, 2'd0, 0, 4'd0, 0, 1, "rst_arm_load");
    run(1, 2'd0, 0, 4'd6, 0, 1, "rst_arm6");
    step(0, 1, 2'd1, 0, 0, 2'd0, 4'd0, 4'd0, 0, 1, 0, "rst_sw_drv");
    run(1, 2'd1, 0, 4'd8, 0, 1, "rst_drv8");
    step(0, 1, 2'd2, 0, 0, 2'd0, 4'd0, 4'd0, 0, 1, 0, "rst_sw_pas");
    run(1, 2'd2, 0, 4'd15, 0, 1, "rst_pas15");
    step(0, 1, 2'd3, 0, 0, 2'd0, 4'd0, 4'd0, 0, 1, 0, "rst_sw_alm");
    run(1, 2'd3, 0, 4'd10, 0, 1, "rst_alm10");
    run(0, 2'd3, 0, 4'd0, 0, 0, "end_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
